rsa_modexp_ctrl: RTL and testbench

RSA_MODEXP_CTRL -- requirements
Module: rsa_modexp_ctrl

---
 rtl/rsa_pkg.sv | 23 ++
 rtl/rsa_prep.sv | 66 ++++++
 rtl/rsa_modexp_ctrl.sv | 149 ++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsa_pkg
// Description : Shared width constant and controller state type for the
//               RSA modular-exponentiation controller.
// Revision    : 1.0 - initial release
// ============================================================================
package rsa_pkg;

    localparam int RSA_WIDTH = 256;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREP     = 3'd1,
        ST_MUL_REQ  = 3'd2,
        ST_MUL_WAIT = 3'd3,
        ST_SQR_REQ  = 3'd4,
        ST_SQR_WAIT = 3'd5,
        ST_DONE     = 3'd6
    } rsa_state_e;

endpackage
`default_nettype wire

// File: rtl/rsa_prep.sv
`default_nettype none
// ============================================================================
// Module      : rsa_prep
// Description : Iterative shift-and-reduce computing t = a * 2^WIDTH mod N,
//               one bit per cycle, WIDTH cycles per job.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_prep #(
    parameter int WIDTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_t,
    output logic             o_done
);

    localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_t;
    logic [WIDTH-1:0] r_n;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;

    logic [WIDTH:0]   w_dbl;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;

    // The carry of 2t takes part in the compare; the difference itself fits
    // in WIDTH bits because t < N keeps 2t - N below N.
    assign w_dbl = {r_t, 1'b0};
    assign w_ge  = (w_dbl >= {1'b0, r_n});
    assign w_sub = w_dbl[WIDTH-1:0] - r_n;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_t    <= '0;
            r_n    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_start && !r_busy) begin
                r_t    <= i_a;
                r_n    <= i_n;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_t   <= w_ge ? w_sub : w_dbl[WIDTH-1:0];
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == C_LAST) begin
                    r_busy <= 1'b0;
                    o_done <= 1'b1;
                end
            end
        end
    end

    assign o_t = r_t;

endmodule
`default_nettype wire

// File: rtl/rsa_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rsa_modexp_ctrl
// Description : Right-to-left binary modular exponentiation a^d mod N driving
//               an external Montgomery multiplier through a start/done port.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_a_pow_d,
    output logic             o_finished,
    output logic             o_mont_start,
    output logic [WIDTH-1:0] o_mont_a,
    output logic [WIDTH-1:0] o_mont_b,
    output logic [WIDTH-1:0] o_mont_n,
    input  logic [WIDTH-1:0] i_mont_m,
    input  logic             i_mont_done
);

    localparam int            IW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] C_LAST_BIT = IW'(WIDTH - 1);

    rsa_state_e       r_state;
    rsa_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_t;
    logic [IW-1:0]    r_i;
    logic [WIDTH-1:0] w_m_nxt;
    logic [WIDTH-1:0] w_t_nxt;
    logic [IW-1:0]    w_i_nxt;
    logic             w_accept;
    logic             w_prep_done;
    logic [WIDTH-1:0] w_prep_t;

    assign w_accept = (r_state == ST_IDLE) && i_start;

    rsa_prep #(
        .WIDTH (WIDTH)
    ) u_prep (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_accept),
        .i_a     (i_a),
        .i_n     (i_n),
        .o_t     (w_prep_t),
        .o_done  (w_prep_done)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // m stays in the normal domain while t carries a^(2^i) * 2^WIDTH, so each
    // Montgomery product mont(m, t) directly yields m * a^(2^i) mod N.
    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m;
        w_t_nxt     = r_t;
        w_i_nxt     = r_i;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_nxt = ST_PREP;
            end
            ST_PREP: begin
                if (w_prep_done) begin
                    w_m_nxt     = {{(WIDTH-1){1'b0}}, 1'b1};
                    w_t_nxt     = w_prep_t;
                    w_i_nxt     = '0;
                    w_state_nxt = r_d[0] ? ST_MUL_REQ : ST_SQR_REQ;
                end
            end
            ST_MUL_REQ:  w_state_nxt = ST_MUL_WAIT;
            ST_MUL_WAIT: begin
                if (i_mont_done) begin
                    w_m_nxt     = i_mont_m;
                    w_state_nxt = ST_SQR_REQ;
                end
            end
            ST_SQR_REQ:  w_state_nxt = ST_SQR_WAIT;
            ST_SQR_WAIT: begin
                if (i_mont_done) begin
                    w_t_nxt = i_mont_m;
                    if (r_i == C_LAST_BIT) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_i_nxt     = r_i + 1'b1;
                        w_state_nxt = r_d[w_i_nxt] ? ST_MUL_REQ : ST_SQR_REQ;
                    end
                end
            end
            ST_DONE:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Operands are loaded on entry to a request state so they are already
    // stable in the cycle o_mont_start is high.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_d          <= '0;
            r_n          <= '0;
            r_m          <= '0;
            r_t          <= '0;
            r_i          <= '0;
            o_mont_start <= 1'b0;
            o_mont_a     <= '0;
            o_mont_b     <= '0;
            o_finished   <= 1'b0;
            o_a_pow_d    <= '0;
        end else begin
            r_m <= w_m_nxt;
            r_t <= w_t_nxt;
            r_i <= w_i_nxt;
            if (w_accept) begin
                r_d <= i_d;
                r_n <= i_n;
            end
            o_mont_start <= (w_state_nxt == ST_MUL_REQ) || (w_state_nxt == ST_SQR_REQ);
            if (w_state_nxt == ST_MUL_REQ) begin
                o_mont_a <= w_m_nxt;
                o_mont_b <= w_t_nxt;
            end else if (w_state_nxt == ST_SQR_REQ) begin
                o_mont_a <= w_t_nxt;
                o_mont_b <= w_t_nxt;
            end
            o_finished <= (w_state_nxt == ST_DONE);
            if (w_state_nxt == ST_DONE) o_a_pow_d <= w_m_nxt;
        end
    end

    assign o_mont_n = r_n;

endmodule
`default_nettype wire

// File: tb/tb_rsa_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsa_modexp_ctrl
// Description : Directed/randomized bench for rsa_modexp_ctrl with a
//               behavioural Montgomery multiplier and golden modpow model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_modexp_ctrl;

    localparam int         W     = 256;
    localparam logic [W-1:0] BIG_N =
        256'hCA3586E7EA485F3B0A222A4C79F7DD12E85388ECCDEE4035940D774C029CF831;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, d, n;
    logic [W-1:0] a_pow_d;
    logic         finished;
    logic         mont_start;
    logic [W-1:0] mont_a, mont_b, mont_n;
    logic [W-1:0] mont_m;
    logic         mont_done;

    int n_cmp       = 0;
    int n_err       = 0;
    int req_total   = 0;
    int rsp_bad     = 0;
    bit hold_resp   = 1'b0;
    bit stale_pulse = 1'b0;

    rsa_modexp_ctrl #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_start      (start),
        .i_a          (a),
        .i_d          (d),
        .i_n          (n),
        .o_a_pow_d    (a_pow_d),
        .o_finished   (finished),
        .o_mont_start (mont_start),
        .o_mont_a     (mont_a),
        .o_mont_b     (mont_b),
        .o_mont_n     (mont_n),
        .i_mont_m     (mont_m),
        .i_mont_done  (mont_done)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < W/32; k++) r = {r[W-33:0], 32'($urandom())};
        return r;
    endfunction

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [W-1:0] nn);
        logic [2*W-1:0] p, r;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        r = p % {{W{1'b0}}, nn};
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] modpow(input logic [W-1:0] x, input logic [W-1:0] e,
                                            input logic [W-1:0] nn);
        logic [W-1:0] acc, base;
        acc  = 1;
        base = x % nn;
        for (int k = 0; k < W; k++) begin
            if (e[k]) acc = mulmod(acc, base, nn);
            base = mulmod(base, base, nn);
        end
        return acc;
    endfunction

    // x*y*2^-W mod N: reduce the product, then halve modulo N W times.
    function automatic logic [W-1:0] mont(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] nn);
        logic [W:0] q;
        q = {1'b0, mulmod(x, y, nn)};
        for (int k = 0; k < W; k++) begin
            if (q[0]) q = q + {1'b0, nn};
            q = q >> 1;
        end
        return q[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input logic [W-1:0] aa, input logic [W-1:0] dd,
                               input logic [W-1:0] nn);
        a = aa; d = dd; n = nn; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = rand_word(); d = rand_word(); n = rand_word();
    endtask

    task automatic wait_finish(input string tag, output logic [W-1:0] res);
        int cyc;
        cyc = 0;
        while (finished !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_finished"}, W'(finished), W'(1));
        res = a_pow_d;
        @(negedge clk);
        check({tag, "_pulse_len"}, W'(finished), W'(0));
    endtask

    // Behavioural multiplier: random 1..20 cycle latency, watches operand
    // stability and the single-outstanding rule while a request is pending.
    initial begin : responder
        logic [W-1:0] ca, cb, cn;
        int lat;
        mont_done = 1'b0;
        mont_m    = '0;
        forever begin
            @(negedge clk);
            mont_done = 1'b0;
            if (stale_pulse) begin
                mont_m      = rand_word();
                mont_done   = 1'b1;
                stale_pulse = 1'b0;
            end else if (mont_start === 1'b1) begin
                ca = mont_a; cb = mont_b; cn = mont_n;
                req_total++;
                if (!hold_resp) begin
                    lat = $urandom_range(1, 20);
                    repeat (lat) begin
                        @(negedge clk);
                        if (mont_start !== 1'b0 || mont_a !== ca || mont_b !== cb || mont_n !== cn)
                            rsp_bad++;
                    end
                    mont_m    = mont(ca, cb, cn);
                    mont_done = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [W-1:0] res, expv, aa, dd, prev;
        int base, cyc;
        start = 1'b0; a = '0; d = '0; n = '0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_result",     a_pow_d,          '0);
        check("rst_finished",   W'(finished),     '0);
        check("rst_mont_start", W'(mont_start),   '0);
        check("rst_mont_a",     mont_a,           '0);
        rst_n = 1'b1;
        @(negedge clk);

        // small modulus
        base = req_total;
        drive_start(W'(3), W'(5), W'(7));
        wait_finish("small", res);
        check("small_result", res, W'(5));
        check("small_reqs", W'(req_total - base), W'(258));

        // d = 0
        base = req_total;
        drive_start(W'(16'h1234), '0, BIG_N);
        wait_finish("d0", res);
        check("d0_result", res, W'(1));
        check("d0_reqs", W'(req_total - base), W'(256));

        // d = 1
        base = req_total;
        drive_start(W'(16'h1234), W'(1), BIG_N);
        wait_finish("d1", res);
        check("d1_result", res, W'(16'h1234));
        check("d1_reqs", W'(req_total - base), W'(257));

        // back-to-back jobs with e = 65537
        prev = res;
        for (int k = 0; k < 5; k++) begin
            aa   = rand_word() % BIG_N;
            expv = modpow(aa, W'(32'h10001), BIG_N);
            base = req_total;
            drive_start(aa, W'(32'h10001), BIG_N);
            check("b2b_hold", a_pow_d, prev);
            wait_finish("b2b", res);
            check("b2b_result", res, expv);
            check("b2b_reqs", W'(req_total - base), W'(258));
            prev = res;
        end

        // restart attempts while busy
        aa   = rand_word() % BIG_N;
        dd   = rand_word();
        expv = modpow(aa, dd, BIG_N);
        base = req_total;
        drive_start(aa, dd, BIG_N);
        repeat (5) @(negedge clk);
        drive_start(W'(3), W'(5), W'(7));
        repeat (600) @(negedge clk);
        drive_start(rand_word() % BIG_N, rand_word(), BIG_N);
        wait_finish("restart", res);
        check("restart_result", res, expv);
        check("restart_reqs", W'(req_total - base), W'(256 + $countones(dd)));

        // reset while a square is outstanding
        hold_resp = 1'b1;
        base = req_total;
        drive_start(rand_word() % BIG_N, W'(32'h10000), BIG_N);
        cyc = 0;
        while (req_total == base && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_req_seen", W'(req_total - base), W'(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_result",     a_pow_d,        '0);
        check("abort_finished",   W'(finished),   '0);
        check("abort_mont_start", W'(mont_start), '0);
        check("abort_mont_a",     mont_a,         '0);
        check("abort_mont_b",     mont_b,         '0);
        check("abort_mont_n",     mont_n,         '0);
        rst_n = 1'b1;
        hold_resp = 1'b0;
        @(negedge clk);
        stale_pulse = 1'b1;
        repeat (6) @(negedge clk);
        check("stale_no_req",   W'(req_total - base), W'(1));
        check("stale_finished", W'(finished),         '0);
        check("stale_result",   a_pow_d,              '0);

        aa   = rand_word() % BIG_N;
        dd   = rand_word();
        expv = modpow(aa, dd, BIG_N);
        base = req_total;
        drive_start(aa, dd, BIG_N);
        wait_finish("post_rst", res);
        check("post_rst_result", res, expv);
        check("post_rst_reqs", W'(req_total - base), W'(256 + $countones(dd)));

        check("mont_protocol", W'(rsp_bad), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
